// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel switch debouncer.
// Optional input synchroniser is enabled by defining DEBOUNCE_SYNC_EN.
package debounce_pkg;

  localparam int SYNC_STAGES = 2;

  function automatic int cnt_width(input int delay);
    return $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_multi_if.sv
// Switch bundle between raw pins and the debouncer.
// Master drives the raw levels, slave returns debounced levels and strobes.
interface switch_debounce_multi_if #(
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0] sw_in;
  logic [CHANNELS-1:0] sw_out;
  logic [CHANNELS-1:0] sw_rise;
  logic [CHANNELS-1:0] sw_fall;
  logic                any_edge;

  modport master (
    output sw_in,
    input  sw_out,
    input  sw_rise,
    input  sw_fall,
    input  any_edge
  );

  modport slave (
    input  sw_in,
    output sw_out,
    output sw_rise,
    output sw_fall,
    output any_edge
  );

endinterface

// File: rtl/debounce_channel.sv
// One debounce lane: optional 2-flop sync, stability counter, level, strobes.
// Define DEBOUNCE_SYNC_EN to insert the synchroniser ahead of the counter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   DELAY = 65535,
  parameter logic INIT  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw,
  output logic o_sw,
  output logic o_rise,
  output logic o_fall,
  output logic o_edge_nxt
);

  localparam int CNT_W = cnt_width(DELAY);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY - 1);

  logic             w_s;
  logic             w_accept;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sw;
  logic             r_rise;
  logic             r_fall;

`ifdef DEBOUNCE_SYNC_EN
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{INIT}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];
`else
  assign w_s = i_sw;
`endif

  // Accept only on the last cycle of an unbroken mismatch run
  assign w_accept = (w_s != r_sw) && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sw   <= INIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_accept & w_s;
      r_fall <= w_accept & ~w_s;
      if (w_s == r_sw || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_sw <= w_s;
      end
    end
  end

  assign o_sw       = r_sw;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_edge_nxt = w_accept;

endmodule

// File: rtl/switch_debounce_multi.sv
// Multi-channel switch debouncer with per-channel rise/fall strobes.
// Define DEBOUNCE_SYNC_EN to add a 2-flop synchroniser per input bit.
module switch_debounce_multi
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS = 4,
  parameter int                  DELAY    = 65535,
  parameter logic [CHANNELS-1:0] INIT     = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  switch_debounce_multi_if.slave bus
);

  logic [CHANNELS-1:0] w_out;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [CHANNELS-1:0] w_edge;
  logic                r_any;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .DELAY (DELAY),
      .INIT  (INIT[g])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_sw       (bus.sw_in[g]),
      .o_sw       (w_out[g]),
      .o_rise     (w_rise[g]),
      .o_fall     (w_fall[g]),
      .o_edge_nxt (w_edge[g])
    );
  end

  // Registered from next-cycle strobes so it lines up with sw_rise/sw_fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_edge;
    end
  end

  assign bus.sw_out   = w_out;
  assign bus.sw_rise  = w_rise;
  assign bus.sw_fall  = w_fall;
  assign bus.any_edge = r_any;

endmodule
